// File: rtl/fifo_pkg.sv
// fifo_pkg: sizing defaults shared by shift_fifo and the arbiter in front of it.
package fifo_pkg;
  localparam int FIFO_DEPTH = 50;
  localparam int FIFO_DATA_W = 8;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin picker, first request after last by rotate / priority-encode / rotate-back.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  logic [2*N-1:0] dbl;
  logic [N-1:0] rot;
  int s;
  int p;
  always_comb begin
    s = (int'(last) + 1) % N;
    dbl = {req, req} >> s;
    rot = dbl[N-1:0];
    p = 0;
    for (int j = N - 1; j >= 0; j--) p = rot[j] ? j : p;
    idx = W'((s + p) % N);
    gnt = '0;
    if (|req) gnt[idx] = 1'b1;
  end
endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin share of one shift_fifo write port, credit-limited to the FIFO depth.
module fifo_rr_arbiter
  import fifo_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH = FIFO_DEPTH,
  localparam int ID_W = $clog2(N_REQ),
  localparam int CRD_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    fifo_write,
  output logic [DATA_W-1:0]       fifo_in,
  output logic [ID_W-1:0]         fifo_id,
  input  logic                    fifo_read,
  output logic [CRD_W-1:0]        credits,
  output logic                    err
);
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic go;
  logic [CRD_W:0] nxt;
  rr_pick #(.N(N_REQ), .W(ID_W)) u_pick (.req(req), .last(last), .gnt(pick_gnt), .idx(pick_idx));
  always_comb begin
    gnt = (!rst && credits != '0) ? pick_gnt : '0;
    go = |gnt;
    nxt = (CRD_W+1)'(credits) - (CRD_W+1)'(go) + (CRD_W+1)'(fifo_read);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_write <= 1'b0;
      fifo_in <= '0;
      fifo_id <= '0;
      credits <= CRD_W'(DEPTH);
      err <= 1'b0;
      last <= ID_W'(N_REQ - 1);
    end else begin
      fifo_write <= go;
      if (go) begin
        last <= pick_idx;
        fifo_in <= req_data[pick_idx*DATA_W +: DATA_W];
        fifo_id <= pick_idx;
      end
      // a credit returned to an already-empty FIFO is dropped and flagged
      credits <= (nxt > (CRD_W+1)'(DEPTH)) ? CRD_W'(DEPTH) : nxt[CRD_W-1:0];
      if (fifo_read && credits == CRD_W'(DEPTH)) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: directed and randomized checks of fifo_rr_arbiter against a behavioural model.
module tb_fifo_rr_arbiter;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int DEPTH = 50;
  logic clk = 0;
  logic rst;
  logic [N-1:0] req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0] gnt;
  logic fifo_write;
  logic [DW-1:0] fifo_in;
  logic [1:0] fifo_id;
  logic fifo_read;
  logic [5:0] credits;
  logic err;
  int n_cmp = 0;
  int n_bad = 0;
  int m_last, m_cred, m_id, lg;
  bit m_err, m_wr, m_ok;
  logic [DW-1:0] m_in;

  fifo_rr_arbiter #(.N_REQ(N), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_write(fifo_write), .fifo_in(fifo_in), .fifo_id(fifo_id),
    .fifo_read(fifo_read), .credits(credits), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // one clock: compare DUT against model just before the edge, then advance the model
  task automatic cyc();
    int g;
    logic [N-1:0] eg;
    #1;
    g = -1;
    if (!rst && m_ok && m_cred > 0)
      for (int j = 1; j <= N && g < 0; j++)
        if (req[(m_last + j) % N]) g = (m_last + j) % N;
    eg = (g >= 0) ? N'(1) << g : '0;
    chk("gnt", int'(gnt), int'(eg));
    if (m_ok) begin
      chk("fifo_write", int'(fifo_write), int'(m_wr));
      chk("fifo_in", int'(fifo_in), int'(m_in));
      chk("fifo_id", int'(fifo_id), m_id);
      chk("credits", int'(credits), m_cred);
      chk("err", int'(err), int'(m_err));
    end
    if (rst) begin
      m_ok = 1; m_wr = 0; m_in = '0; m_id = 0; m_cred = DEPTH; m_err = 0; m_last = N - 1;
    end else if (m_ok) begin
      if (fifo_read && m_cred == DEPTH) m_err = 1;
      m_wr = g >= 0;
      if (g >= 0) begin
        m_last = g; m_in = req_data[g*DW +: DW]; m_id = g;
      end
      m_cred = m_cred - (g >= 0 ? 1 : 0) + (fifo_read ? 1 : 0);
      if (m_cred > DEPTH) m_cred = DEPTH;
    end
    lg = g;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; req = '0; fifo_read = 0;
    cyc();
    rst = 0;
  endtask

  initial begin
    int cnt;
    rst = 1; req = '0; fifo_read = 0;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(8'h10 + i);
    m_ok = 0;
    @(negedge clk);
    do_reset();
    chk("reset credits", int'(credits), DEPTH);
    chk("reset fifo_write", int'(fifo_write), 0);
    // 1: all requesting -> 0,1,2,3,0
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("order1111", lg, i % N);
    end
    chk("fifo_id lag", int'(fifo_id), 0);
    // 2: 0101 -> 0,2,0,2 with matching data
    do_reset();
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("order0101", lg, (i % 2) * 2);
    end
    chk("fifo_in slot2", int'(fifo_in), 8'h12);
    // 3: fill until credits run out
    do_reset();
    req = 4'b1111; cnt = 0;
    for (int i = 0; i < 55; i++) begin
      cyc();
      if (lg >= 0) cnt++;
    end
    chk("fill writes", cnt, DEPTH);
    chk("fill credits", int'(credits), 0);
    chk("fill gnt", int'(gnt), 0);
    // 4: one returned credit allows exactly one grant
    fifo_read = 1;
    cyc();
    fifo_read = 0;
    chk("credit back", int'(credits), 1);
    cyc();
    chk("one gnt", int'(lg >= 0), 1);
    chk("credits empty", int'(credits), 0);
    // 5: grant and read together at credits=10
    req = '0; fifo_read = 1;
    for (int i = 0; i < 10; i++) cyc();
    chk("credits 10", int'(credits), 10);
    req = 4'b0001;
    cyc();
    req = '0; fifo_read = 0;
    chk("grant+read", int'(credits), 10);
    // 6: bogus read at full credit -> sticky err
    do_reset();
    fifo_read = 1;
    cyc();
    fifo_read = 0;
    cyc(); cyc();
    chk("err sticky", int'(err), 1);
    chk("err credits", int'(credits), DEPTH);
    req = 4'b0010;
    cyc();
    do_reset();
    chk("rst err", int'(err), 0);
    chk("rst fifo_write", int'(fifo_write), 0);
    // randomized traffic with occasional drops, bogus reads and resets
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!req[k] && $urandom_range(2) == 0) begin
          req[k] = 1; req_data[k*DW +: DW] = DW'($urandom);
        end else if (req[k] && $urandom_range(19) == 0) req[k] = 0;
      end
      fifo_read = (m_cred < DEPTH) ? ($urandom_range(9) < 4) : ($urandom_range(49) == 0);
      rst = $urandom_range(499) == 0;
      cyc();
      if (lg >= 0) req[lg] = 0;
    end
    rst = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
